// File: rtl/control_unit.sv
// control_unit: instruction sequencer for venera_cpu_1.
// Fetches 8-bit instructions from the shared memory, decodes them and drives the
// accumulator load strobe, the ALU strobe and memory writes. Sole master of the memory port.
//
// Instruction: [7:5] opcode, [4:0] address A.
//   000 LDA  001 STA  010 ADD  011 SUB  100 JMP  101 JZ  110 NOP  111 HLT
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   o_mem_addr/o_mem_rd      read request (held until i_mem_rvalid)
//   i_mem_rvalid/i_mem_rdata read response
//   o_mem_wr/o_mem_wdata     single-cycle write of the accumulator
//   i_acc_data               current accumulator value
//   o_acc_mem_valid/_data    load accumulator from memory operand
//   o_alu_valid/o_alu_op/o_alu_operand  ALU ADD(0)/SUB(1) result into accumulator
//   o_pc, o_halt, o_error    program counter, halted, memory timeout
//
// Optional feature: define CU_MEM_TIMEOUT_EN to halt with o_error=1 when a read
// has waited 16 cycles without i_mem_rvalid.

`timescale 1ns / 1ps

module control_unit #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  input  logic              i_mem_rvalid,
  input  logic [7:0]        i_mem_rdata,
  output logic              o_mem_wr,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_acc_data,
  output logic              o_acc_mem_valid,
  output logic [7:0]        o_acc_mem_data,
  output logic              o_alu_valid,
  output logic              o_alu_op,
  output logic [7:0]        o_alu_operand,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_halt,
  output logic              o_error
);

  typedef enum logic [2:0] {StFetch, StDecode, StExecRd, StExecWr, StHalt} state_e;

  localparam logic [2:0] OpLda = 3'b000;
  localparam logic [2:0] OpSta = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b011;
  localparam logic [2:0] OpJmp = 3'b100;
  localparam logic [2:0] OpJz  = 3'b101;
  localparam logic [2:0] OpNop = 3'b110;
  localparam logic [2:0] OpHlt = 3'b111;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [2:0]        opcode;
  logic [ADDR_W-1:0] operand_addr;

  assign opcode       = ir_q[7:5];
  assign operand_addr = ir_q[ADDR_W-1:0];

`ifdef CU_MEM_TIMEOUT_EN
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;
  logic       timeout;
  // Counter has already seen 15 empty cycles and this one is empty too.
  assign timeout = (wait_cnt_q == 4'd15) && !i_mem_rvalid;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StFetch;
      pc_q       <= '0;
      ir_q       <= '0;
`ifdef CU_MEM_TIMEOUT_EN
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
`ifdef CU_MEM_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef CU_MEM_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      StFetch: begin
        if (i_mem_rvalid) begin
          ir_d    = i_mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = StDecode;
`ifdef CU_MEM_TIMEOUT_EN
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StHalt;
`endif
        end
      end
      StDecode: begin
        unique case (opcode)
          OpLda, OpAdd, OpSub: state_d = StExecRd;
          OpSta:               state_d = StExecWr;
          OpJmp: begin
            pc_d    = operand_addr;
            state_d = StFetch;
          end
          OpJz: begin
            if (i_acc_data == 8'h00) pc_d = operand_addr;
            state_d = StFetch;
          end
          OpNop:               state_d = StFetch;
          OpHlt:               state_d = StHalt;
          default:             state_d = StFetch;
        endcase
      end
      StExecRd: begin
        if (i_mem_rvalid) begin
          state_d = StFetch;
`ifdef CU_MEM_TIMEOUT_EN
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StHalt;
`endif
        end
      end
      StExecWr: state_d = StFetch;
      StHalt:   state_d = StHalt;
      default:  state_d = StFetch;
    endcase
  end

`ifdef CU_MEM_TIMEOUT_EN
  // Any state change is an entry into a new wait window; only read states count.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if ((state_q == StFetch || state_q == StExecRd) && !i_mem_rvalid) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end
  assign o_error = err_q;
`else
  assign o_error = 1'b0;
`endif

  // Output logic; write and load strobes are suppressed while reset is asserted.
  always_comb begin
    o_mem_addr      = pc_q;
    o_mem_rd        = 1'b0;
    o_mem_wr        = 1'b0;
    o_acc_mem_valid = 1'b0;
    o_alu_valid     = 1'b0;
    o_halt          = 1'b0;
    unique case (state_q)
      StFetch: begin
        o_mem_addr = pc_q;
        o_mem_rd   = 1'b1;
      end
      StExecRd: begin
        o_mem_addr = operand_addr;
        o_mem_rd   = 1'b1;
        if (i_mem_rvalid && !i_reset) begin
          if (opcode == OpLda) o_acc_mem_valid = 1'b1;
          else                 o_alu_valid     = 1'b1;
        end
      end
      StExecWr: begin
        o_mem_addr = operand_addr;
        o_mem_wr   = !i_reset;
      end
      StHalt:   o_halt = 1'b1;
      default:  ;
    endcase
  end

  assign o_mem_wdata    = i_acc_data;
  assign o_acc_mem_data = i_mem_rdata;
  assign o_alu_operand  = i_mem_rdata;
  assign o_alu_op       = ir_q[5];  // 010 ADD / 011 SUB differ only in bit 5
  assign o_pc           = pc_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: small memory model with programmable read latency,
// a bench-side accumulator, and hand-computed expectations.

`timescale 1ns / 1ps

module tb_control_unit;

  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_rvalid;
  logic [7:0]    mem_rdata;
  logic          mem_wr;
  logic [7:0]    mem_wdata;
  logic [7:0]    acc;
  logic          acc_mem_valid;
  logic [7:0]    acc_mem_data;
  logic          alu_valid;
  logic          alu_op;
  logic [7:0]    alu_operand;
  logic [AW-1:0] pc;
  logic          halt;
  logic          error;

  control_unit #(.ADDR_W(AW)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .o_mem_addr     (mem_addr),
    .o_mem_rd       (mem_rd),
    .i_mem_rvalid   (mem_rvalid),
    .i_mem_rdata    (mem_rdata),
    .o_mem_wr       (mem_wr),
    .o_mem_wdata    (mem_wdata),
    .i_acc_data     (acc),
    .o_acc_mem_valid(acc_mem_valid),
    .o_acc_mem_data (acc_mem_data),
    .o_alu_valid    (alu_valid),
    .o_alu_op       (alu_op),
    .o_alu_operand  (alu_operand),
    .o_pc           (pc),
    .o_halt         (halt),
    .o_error        (error)
  );

  always #5 clk = ~clk;

  // Memory model: rvalid appears `lat` cycles after rd is first seen.
  logic [7:0]  mem [32];
  int unsigned lat = 1;
  bit          no_resp = 1'b0;
  int unsigned mem_wait;

  always @(posedge clk) begin
    if (reset) begin
      mem_rvalid <= 1'b0;
      mem_wait   <= 0;
    end else if (mem_rd && !mem_rvalid && !no_resp) begin
      if (mem_wait + 1 >= lat) begin
        mem_rvalid <= 1'b1;
        mem_rdata  <= mem[mem_addr];
        mem_wait   <= 0;
      end else begin
        mem_wait <= mem_wait + 1;
      end
    end else begin
      mem_rvalid <= 1'b0;
    end
  end

  // Accumulator as the CPU datapath would hold it.
  always @(posedge clk) begin
    if (reset)              acc <= 8'h00;
    else if (acc_mem_valid) acc <= acc_mem_data;
    else if (alu_valid)     acc <= alu_op ? acc - alu_operand : acc + alu_operand;
  end

  // Monitors; a write seen while in reset is kept so it can be reported.
  int unsigned   wr_cnt, acc_pulses, alu_pulses, overlap, rd_waits;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          last_op;
  logic [7:0]    last_operand;

  always @(posedge clk) begin
    if (mem_wr) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end else if (reset) begin
      wr_cnt <= 0;
    end
    if (reset) begin
      acc_pulses <= 0;
      alu_pulses <= 0;
      overlap    <= 0;
      rd_waits   <= 0;
    end else begin
      if (acc_mem_valid) acc_pulses <= acc_pulses + 1;
      if (alu_valid) begin
        alu_pulses   <= alu_pulses + 1;
        last_op      <= alu_op;
        last_operand <= alu_operand;
      end
      if (acc_mem_valid && alu_valid) overlap <= overlap + 1;
      if (mem_rd && !mem_rvalid) rd_waits <= rd_waits + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'hE0;  // HLT everywhere stops runaways
  endtask

  // Leaves reset deasserted at a negedge; the next cycle is the first FETCH cycle.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_halt(input int bound, output int n);
    n = 0;
    while (!halt && n < bound) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  int n;

  initial begin
    reset = 1'b1;
    lat   = 1;

    // Reset state and program LDA 10, ADD 11, STA 12, HLT
    clear_mem();
    mem[0] = 8'h0A; mem[1] = 8'h4B; mem[2] = 8'h2C; mem[3] = 8'hE0;
    mem[10] = 8'h05; mem[11] = 8'h07;
    do_reset();
    #1;
    check("rst_pc", 32'(pc), 0);
    check("rst_halt", 32'(halt), 0);
    check("rst_error", 32'(error), 0);
    check("rst_addr", 32'(mem_addr), 0);
    check("rst_wr", 32'(mem_wr), 0);
    check("rst_rd_fetch", 32'(mem_rd), 1);
    @(negedge clk);
    run_until_halt(100, n);
    check("prog_cycles", 32'(n + 1), 17);  // +1: the reset-exit cycle consumed above
    check("prog_halt", 32'(halt), 1);
    check("prog_pc", 32'(pc), 4);
    check("prog_wr_cnt", wr_cnt, 1);
    check("prog_wr_addr", 32'(wr_addr), 12);
    check("prog_wr_data", 32'(wr_data), 32'h0C);
    check("prog_acc", 32'(acc), 32'h0C);
    check("prog_no_overlap", overlap, 0);

    // SUB 5 with M[5]=1 from AC=0
    clear_mem();
    mem[0] = 8'h65; mem[1] = 8'hE0; mem[5] = 8'h01;
    do_reset();
    run_until_halt(100, n);
    check("sub_pulses", alu_pulses, 1);
    check("sub_op", 32'(last_op), 1);
    check("sub_operand", 32'(last_operand), 1);
    check("sub_acc", 32'(acc), 32'hFF);
    check("sub_no_load", acc_pulses, 0);

    // JZ 20 taken with AC=0
    clear_mem();
    mem[0] = 8'hB4;
    do_reset();
    run_cycles(3);
    check("jz_taken_pc", 32'(pc), 20);

    // LDA 6 (=3) then JZ 20 not taken
    clear_mem();
    mem[0] = 8'h06; mem[1] = 8'hB4; mem[6] = 8'h03;
    do_reset();
    run_cycles(8);
    check("jz_not_taken_pc", 32'(pc), 2);
    check("jz_acc", 32'(acc), 3);

    // JMP 31, then JMP 0 at address 31
    clear_mem();
    mem[0] = 8'h9F; mem[31] = 8'h80;
    do_reset();
    run_cycles(3);
    check("jmp31_pc", 32'(pc), 31);
    run_cycles(2);
    check("fetch31_wrap_pc", 32'(pc), 0);
    run_cycles(1);
    check("jmp0_pc", 32'(pc), 0);
    run_cycles(3);
    check("jmp31_again_pc", 32'(pc), 31);

    // NOP at address 31 wraps PC
    mem[31] = 8'hC0;
    do_reset();
    run_cycles(6);
    check("nop31_wrap_pc", 32'(pc), 0);
    check("nop31_rd", 32'(mem_rd), 1);

    // LDA with 3-cycle read latency: 9 cycles, single load pulse
    clear_mem();
    mem[0] = 8'h0A; mem[10] = 8'h5A;
    lat = 3;
    do_reset();
    run_cycles(8);
    check("slow_lda_acc_early", 32'(acc), 0);
    run_cycles(1);
    check("slow_lda_acc", 32'(acc), 32'h5A);
    check("slow_lda_pulses", acc_pulses, 1);
    check("slow_lda_rd_waits", rd_waits, 6);
    check("slow_lda_pc", 32'(pc), 1);
    lat = 1;

    // Reset during EXEC_WR of STA 12
    clear_mem();
    mem[0] = 8'h2C;
    do_reset();
    run_cycles(3);
    reset = 1'b1;
    #1;
    check("rst_exec_wr_strobe", 32'(mem_wr), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_exec_wr_cnt", wr_cnt, 0);
    check("rst_exec_pc", 32'(pc), 0);
    check("rst_exec_fetch", 32'(mem_rd), 1);
    check("rst_exec_addr", 32'(mem_addr), 0);

    // Memory never answers
    clear_mem();
    no_resp = 1'b1;
    do_reset();
`ifdef CU_MEM_TIMEOUT_EN
    run_cycles(15);
    check("to_not_yet", 32'(halt), 0);
    run_cycles(1);
    check("to_halt", 32'(halt), 1);
    check("to_error", 32'(error), 1);
    check("to_no_load", acc_pulses, 0);
    run_cycles(3);
    check("to_error_sticky", 32'(error), 1);
    check("to_no_rd", 32'(mem_rd), 0);
`else
    run_cycles(40);
    check("stall_halt", 32'(halt), 0);
    check("stall_rd", 32'(mem_rd), 1);
    check("stall_error", 32'(error), 0);
    check("stall_pc", 32'(pc), 0);
`endif
    no_resp = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
